// File: rtl/updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// updown_counter_pkg
//
// Purpose: shared types and constants for the parametrised up/down counter.
//   cnt_mode_e  : counting behaviour at the bounds (wrap or saturate)
//   DIR_UP/DOWN : encoding of the sel input
//   step_evt_t  : bound events decoded for one counting step. The top module
//                 uses them to form the wrap pulse and the optional sticky
//                 flags.
//
// Optional feature macro used by the files that import this package:
//   UPDOWN_COUNTER_STICKY_FLAGS_EN
// ---------------------------------------------------------------------------
package updown_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bound events for a single count step. At most one field is set per step.
    typedef struct packed {
        logic wrap_up;       // up step past max_val, wrapped to 0
        logic wrap_down;     // down step below 0, wrapped to max_val
        logic blocked_up;    // up step held at max_val by saturation
        logic blocked_down;  // down step held at 0 by saturation
    } step_evt_t;

    // Clamp a value to an inclusive upper bound.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                 input logic [31:0] bound);
        return (value > bound) ? bound : value;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// ---------------------------------------------------------------------------
// updown_counter_next
//
// Purpose: purely combinational next-value decode for the up/down counter.
// It decides what out becomes on the next enabled edge and which bound event
// that step produces. Gating by en, and all state, belong to the top module.
//
// Ports:
//   count    in  WIDTH  current registered count
//   max_val  in  WIDTH  inclusive upper bound (lower bound is 0)
//   sel      in  1      direction, DIR_UP / DIR_DOWN
//   mode     in  1      MODE_WRAP / MODE_SAT
//   load     in  1      load strobe, overrides counting
//   load_val in  WIDTH  value to load, clamped to max_val
//   next_val out WIDTH  value for out if this edge steps or loads
//   evt      out 4      bound events; all zero on a load
//
// Optional feature macro: none used here. UPDOWN_COUNTER_STICKY_FLAGS_EN is
// handled in the top module.
// ---------------------------------------------------------------------------
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sel,
    input  cnt_mode_e        mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_val,
    output step_evt_t        evt
);

    logic at_or_above_max;
    logic above_max;
    logic at_zero;
    logic [WIDTH-1:0] load_clamped;

    // Every compare is a plain WIDTH-bit unsigned compare. The +1 happens
    // only when count < max_val, so it cannot overflow, and the -1 happens
    // only when count > 0, so it cannot underflow.
    assign at_or_above_max = (count >= max_val);
    assign above_max       = (count > max_val);
    assign at_zero         = (count == '0);
    assign load_clamped    = (load_val > max_val) ? max_val : load_val;

    always_comb begin
        next_val = count;
        evt      = '0;

        if (load) begin
            next_val = load_clamped;
        end else if (sel == DIR_UP) begin
            if (!at_or_above_max) begin
                next_val = count + 1'b1;
            end else if (mode == MODE_WRAP) begin
                next_val    = '0;
                evt.wrap_up = 1'b1;
            end else begin
                // Saturate, and also pull a count that sits above a lowered
                // bound back down to it.
                next_val       = max_val;
                evt.blocked_up = 1'b1;
            end
        end else begin
            if (above_max) begin
                // The bound was lowered under the count. Both modes clamp,
                // and this is not a wrap.
                next_val = max_val;
            end else if (!at_zero) begin
                next_val = count - 1'b1;
            end else if (mode == MODE_WRAP) begin
                next_val      = max_val;
                evt.wrap_down = 1'b1;
            end else begin
                next_val         = count;
                evt.blocked_down = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//
// Purpose: parametrised up/down event/timer counter with a run-time upper
// bound, wrap or saturate behaviour, synchronous load and terminal-count
// outputs. This module holds the flops. The step decode is in
// updown_counter_next.
//
// Parameters:
//   WIDTH   counter width in bits (>= 2)
//   RST_VAL value of out after reset
//
// Ports:
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   en        in  1      count enable
//   sel       in  1      1 = up, 0 = down
//   mode      in  1      0 = wrap, 1 = saturate
//   load      in  1      synchronous load strobe (priority over en)
//   load_val  in  WIDTH  value to load (clamped to max_val)
//   max_val   in  WIDTH  inclusive upper bound
//   out       out WIDTH  registered count
//   tc_max    out 1      combinational out == max_val
//   tc_min    out 1      combinational out == 0
//   wrap      out 1      registered one-cycle pulse that accompanies a
//                        wrapped value of out
//   With UPDOWN_COUNTER_STICKY_FLAGS_EN defined, these ports are added:
//   clr_flags in  1      clears ovf/unf (wins over a same-cycle set)
//   ovf       out 1      sticky: up wrap or saturation-blocked up step
//   unf       out 1      sticky: down wrap or saturation-blocked down step
//
// Optional feature macro: UPDOWN_COUNTER_STICKY_FLAGS_EN
// ---------------------------------------------------------------------------
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] out,
    output logic             tc_max,
    output logic             tc_min,
    output logic             wrap
`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
    ,
    input  logic             clr_flags,
    output logic             ovf,
    output logic             unf
`endif
);

    logic [WIDTH-1:0] next_val;
    step_evt_t        evt;
    logic             step;
    logic             count_step;

    updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count    (out),
        .max_val  (max_val),
        .sel      (sel),
        .mode     (cnt_mode_e'(mode)),
        .load     (load),
        .load_val (load_val),
        .next_val (next_val),
        .evt      (evt)
    );

    // A load updates out even when en is low. The decode has already given
    // load priority, so next_val is the clamped load value in that case.
    assign step       = load | en;
    assign count_step = en & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            if (step) begin
                out <= next_val;
            end
            // Registered alongside out, so the pulse lines up with the
            // wrapped value. It drops on loads and holds.
            wrap <= count_step & (evt.wrap_up | evt.wrap_down);
        end
    end

    assign tc_max = (out == max_val);
    assign tc_min = (out == '0);

`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = count_step & (evt.wrap_up   | evt.blocked_up);
    assign unf_set = count_step & (evt.wrap_down | evt.blocked_down);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr_flags) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set) ovf <= 1'b1;
            if (unf_set) unf <= 1'b1;
        end
    end
`else
    // Without the sticky flags, the blocked events have no consumer.
    logic unused_evt;
    assign unused_evt = evt.blocked_up | evt.blocked_down;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//
// Bench for updown_counter_param with WIDTH=4 and RST_VAL=0. It runs a reset
// check, a directed full-range up wrap, a table of hand-computed vectors for
// the bound, load and saturate corners, and a randomized run checked against
// an integer reference model. Builds with or without
// UPDOWN_COUNTER_STICKY_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sel = 1'b0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] max_val = '0;
    logic [W-1:0] out;
    logic         tc_max;
    logic         tc_min;
    logic         wrap;
`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
    logic         clr_flags = 1'b0;
    logic         ovf;
    logic         unf;
`endif

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH   (W),
        .RST_VAL (4'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sel       (sel),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .max_val   (max_val),
        .out       (out),
        .tc_max    (tc_max),
        .tc_min    (tc_min),
        .wrap      (wrap)
`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
        ,
        .clr_flags (clr_flags),
        .ovf       (ovf),
        .unf       (unf)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model works on plain integers and follows the behavioural rules
    // one at a time. The expected wrap value is 0 or 1.
    int m_out  = 0;
    int m_wrap = 0;
    int m_ovf  = 0;
    int m_unf  = 0;

    task automatic model_step(input int e, input int s, input int md, input int ld,
                              input int lv, input int mv, input int clr);
        int up_ev;
        int dn_ev;
        up_ev  = 0;
        dn_ev  = 0;
        m_wrap = 0;
        if (ld != 0) begin
            m_out = (lv < mv) ? lv : mv;
        end else if (e != 0) begin
            if (s != 0) begin
                if (m_out < mv) m_out = m_out + 1;
                else begin
                    up_ev = 1;
                    if (md == 0) begin m_out = 0; m_wrap = 1; end
                    else m_out = mv;
                end
            end else begin
                if (m_out > mv) m_out = mv;
                else if (m_out > 0) m_out = m_out - 1;
                else begin
                    dn_ev = 1;
                    if (md == 0) begin m_out = mv; m_wrap = 1; end
                end
            end
        end
        if (clr != 0) begin
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (up_ev != 0) m_ovf = 1;
            if (dn_ev != 0) m_unf = 1;
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns after
    // the edge that consumed them.
    task automatic apply(input int e, input int s, input int md, input int ld,
                         input int lv, input int mv, input int clr);
        en       = 1'(e);
        sel      = 1'(s);
        mode     = 1'(md);
        load     = 1'(ld);
        load_val = W'(lv);
        max_val  = W'(mv);
`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
        clr_flags = 1'(clr);
`endif
        @(posedge clk);
        model_step(e, s, md, ld, lv, mv, clr);
        #1;
    endtask

    task automatic check_flags(input string tag);
`ifdef UPDOWN_COUNTER_STICKY_FLAGS_EN
        check({tag, ".ovf"}, int'(ovf), m_ovf);
        check({tag, ".unf"}, int'(unf), m_unf);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int en, sel, mode, load, lv, mv;
        int out, wrap, tcmax, tcmin;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // Every row starts from the out value left by the previous row.
        //             en sel md ld lv  mv  out wr tmx tmn
        vecs[0]  = '{1, 0, 0, 0,  0, 9,  9, 1, 1, 0};  // down wrap 0 -> 9
        vecs[1]  = '{0, 0, 0, 1,  0, 9,  0, 0, 0, 1};  // load 0
        vecs[2]  = '{1, 0, 1, 0,  0, 9,  0, 0, 0, 1};  // down saturate holds 0
        vecs[3]  = '{0, 1, 0, 0,  0, 9,  0, 0, 0, 1};  // hold
        vecs[4]  = '{0, 1, 1, 1,  7, 9,  7, 0, 0, 0};  // load 7 with en low
        vecs[5]  = '{1, 1, 1, 0,  0, 9,  8, 0, 0, 0};
        vecs[6]  = '{1, 1, 1, 0,  0, 9,  9, 0, 1, 0};
        vecs[7]  = '{1, 1, 1, 0,  0, 9,  9, 0, 1, 0};  // saturated at bound
        vecs[8]  = '{1, 1, 1, 0,  0, 9,  9, 0, 1, 0};
        vecs[9]  = '{1, 0, 1, 0,  0, 5,  5, 0, 1, 0};  // bound lowered under out
        vecs[10] = '{1, 1, 0, 1, 12, 9,  9, 0, 1, 0};  // load clamped, beats count
        vecs[11] = '{1, 1, 0, 1,  3, 9,  3, 0, 0, 0};  // load 3, beats count
        vecs[12] = '{1, 1, 0, 0,  0, 0,  0, 1, 1, 1};  // max 0, wrap each step
        vecs[13] = '{1, 1, 0, 0,  0, 0,  0, 1, 1, 1};
        vecs[14] = '{1, 1, 1, 0,  0, 0,  0, 0, 1, 1};  // max 0 saturate, no wrap
        vecs[15] = '{1, 0, 0, 0,  0, 0,  0, 1, 1, 1};  // max 0 down wrap
        vecs[16] = '{0, 0, 0, 1, 15, 15, 15, 0, 1, 0};
        vecs[17] = '{1, 1, 0, 0,  0, 15, 0, 1, 0, 1};  // full-range up wrap
        vecs[18] = '{0, 1, 0, 0,  0, 15, 0, 0, 0, 1};  // wrap lasts one cycle
    end

    // ---------------- test sequence ----------------
    initial begin
        int e, s, md, ld, lv, mv, clr;

        // 1. Reset
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset.out", int'(out), 0);
        check("reset.tc_min", int'(tc_min), 1);
        check("reset.wrap", int'(wrap), 0);
        check_flags("reset");

        // Count to 7, then assert reset between edges.
        for (int i = 0; i < 7; i++) apply(1, 1, 0, 0, 0, 15, 0);
        check("pre_reset.out", int'(out), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.out", int'(out), 0);
        check("async_reset.wrap", int'(wrap), 0);
        m_out = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
        #3;
        rst_n = 1'b1;

        // 2. Full-range up wrap: 1..15, then 0 with wrap
        for (int i = 0; i < 16; i++) begin
            apply(1, 1, 0, 0, 0, 15, 0);
            check("upwrap.out", int'(out), (i + 1) % 16);
            check("upwrap.wrap", int'(wrap), (i == 15) ? 1 : 0);
            check("upwrap.tc_max", int'(tc_max), (i == 14) ? 1 : 0);
        end

        // 3-5. Table vectors for bound, saturate and load corners
        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].en, vecs[i].sel, vecs[i].mode, vecs[i].load,
                  vecs[i].lv, vecs[i].mv, 0);
            check($sformatf("vec%0d.out", i), int'(out), vecs[i].out);
            check($sformatf("vec%0d.wrap", i), int'(wrap), vecs[i].wrap);
            check($sformatf("vec%0d.tc_max", i), int'(tc_max), vecs[i].tcmax);
            check($sformatf("vec%0d.tc_min", i), int'(tc_min), vecs[i].tcmin);
            check_flags($sformatf("vec%0d", i));
        end

        // 6. Random run against the reference model
        mv = 9;
        for (int i = 0; i < 100; i++) begin
            e   = int'($urandom_range(0, 3) != 0);
            s   = int'($urandom_range(0, 1));
            md  = int'($urandom_range(0, 1));
            ld  = int'($urandom_range(0, 7) == 0);
            lv  = int'($urandom_range(0, 15));
            clr = int'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) mv = int'($urandom_range(0, 15));
            apply(e, s, md, ld, lv, mv, clr);
            check("rand.out", int'(out), m_out);
            check("rand.wrap", int'(wrap), m_wrap);
            check("rand.tc_max", int'(tc_max), (m_out == mv) ? 1 : 0);
            check("rand.tc_min", int'(tc_min), (m_out == 0) ? 1 : 0);
            check_flags("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
